// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between a read-only fetch port
// and a read/write data port; one access in flight, data-first with starvation bound.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Handshake: a port raises req with its address/data and holds them until its
  // 1-cycle gnt (ISSUE); the 1-cycle ack (RESP) marks store done / rdata valid.
  // Holding req past gnt requests a further access; req is only looked at in IDLE/RESP.

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [SC_W-1:0]   starve_cnt, starve_nx;
  logic              sel_d, sel_d_nx;
  logic              we_q, we_nx;
  logic              pick_d;
  logic              starve_full;

  logic              if_gnt_nx, if_ack_nx, d_gnt_nx, d_ack_nx;
  logic              mem_en_nx, mem_we_nx, busy_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx, if_rdata_nx, d_rdata_nx;

  assign starve_full = (starve_cnt == SC_W'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      sel_d      <= 1'b0;
      we_q       <= 1'b0;
      if_gnt     <= 1'b0;
      if_ack     <= 1'b0;
      d_gnt      <= 1'b0;
      d_ack      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      starve_cnt <= starve_nx;
      sel_d      <= sel_d_nx;
      we_q       <= we_nx;
      if_gnt     <= if_gnt_nx;
      if_ack     <= if_ack_nx;
      d_gnt      <= d_gnt_nx;
      d_ack      <= d_ack_nx;
      mem_en     <= mem_en_nx;
      mem_we     <= mem_we_nx;
      busy       <= busy_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      if_rdata   <= if_rdata_nx;
      d_rdata    <= d_rdata_nx;
    end
  end

  // Outputs are computed for the state being entered and registered with it.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    starve_nx    = starve_cnt;
    sel_d_nx     = sel_d;
    we_nx        = we_q;
    pick_d       = 1'b0;
    if_gnt_nx    = 1'b0;
    if_ack_nx    = 1'b0;
    d_gnt_nx     = 1'b0;
    d_ack_nx     = 1'b0;
    mem_en_nx    = 1'b0;
    mem_we_nx    = 1'b0;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    if_rdata_nx  = if_rdata;
    d_rdata_nx   = d_rdata;

    case (state)
      IDLE, RESP: begin
        if (if_req || d_req) begin
          pick_d    = d_req && !(if_req && starve_full);
          state_nx  = ISSUE;
          sel_d_nx  = pick_d;
          we_nx     = pick_d && d_we;
          mem_en_nx = 1'b1;
          mem_we_nx = pick_d && d_we;
          if_gnt_nx = !pick_d;
          d_gnt_nx  = pick_d;
          if (pick_d) begin
            mem_addr_nx  = d_addr;
            mem_wdata_nx = d_wdata;
            if (if_req && !starve_full) starve_nx = starve_cnt + 1'b1;
          end else begin
            mem_addr_nx = if_addr;
            starve_nx   = '0;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_nx = RESP;
          d_ack_nx = 1'b1;
        end else begin
          state_nx = WAIT;
          cnt_nx   = CNT_W'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx = RESP;
          if (sel_d) begin
            d_rdata_nx = mem_rdata;
            d_ack_nx   = 1'b1;
          end else begin
            if_rdata_nx = mem_rdata;
            if_ack_nx   = 1'b1;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

endmodule
